// File: rtl/gf_alpha_table_if.sv
// -----------------------------------------------------------------------------
// gf_alpha_table_if
// Request/response bundle between the RS decoder root loader (master) and the
// GF(2^8) power table (slave).
//   address            master->slave  exponent a of the request
//   read_alpha         master->slave  request alpha^a
//   read_alpha_inverse master->slave  request alpha^-a
//   read_log           master->slave  request log(a)   (GF_LOG_LOOKUP_EN only)
//   alpha              slave->master  result word, holds between responses
//   gf_table_ready     slave->master  one-cycle pulse, alpha valid this cycle
//   table_init_done    slave->master  table built, stays high until reset
// Optional feature macro: GF_LOG_LOOKUP_EN adds the read_log strobe.
// -----------------------------------------------------------------------------
interface gf_alpha_table_if;
  logic [7:0] address;
  logic       read_alpha;
  logic       read_alpha_inverse;
`ifdef GF_LOG_LOOKUP_EN
  logic       read_log;
`endif
  logic [7:0] alpha;
  logic       gf_table_ready;
  logic       table_init_done;

`ifdef GF_LOG_LOOKUP_EN
  modport master (
    output address, read_alpha, read_alpha_inverse, read_log,
    input  alpha, gf_table_ready, table_init_done
  );
  modport slave (
    input  address, read_alpha, read_alpha_inverse, read_log,
    output alpha, gf_table_ready, table_init_done
  );
`else
  modport master (
    output address, read_alpha, read_alpha_inverse,
    input  alpha, gf_table_ready, table_init_done
  );
  modport slave (
    input  address, read_alpha, read_alpha_inverse,
    output alpha, gf_table_ready, table_init_done
  );
`endif
endinterface

// File: rtl/gf_alpha_table.sv
// -----------------------------------------------------------------------------
// gf_alpha_table
// GF(2^8) power-table responder (primitive polynomial 0x11D). After reset the
// antilog table exp[i] = alpha^i, i = 0..254, is generated one entry per clock
// by a shift-and-reduce generator (255 edges). The block then answers
// single-word requests for alpha^a / alpha^-a with one cycle of latency.
// Requests seen while the table is still being built are held in a one-deep
// pending slot (newest wins) and served on the first serve edge.
//
// Ports:
//   clock  in   sole clock, rising edge
//   reset  in   synchronous, active-high; restarts the table build
//   tbl    slave modport of gf_alpha_table_if (request strobes, address,
//          alpha result, gf_table_ready pulse, table_init_done flag)
//
// Optional feature macro: GF_LOG_LOOKUP_EN
//   adds the read_log strobe and a 256x8 log table (log(0) reads as 8'hFF).
//   Priority: read_alpha > read_alpha_inverse > read_log.
// -----------------------------------------------------------------------------
module gf_alpha_table (
  input  logic             clock,
  input  logic             reset,
  gf_alpha_table_if.slave  tbl
);

  typedef enum logic {
    ST_INIT,
    ST_SERVE
  } state_e;

  typedef enum logic [1:0] {
    REQ_ALPHA,
    REQ_INV,
    REQ_LOG
  } req_kind_e;

  // Low byte of the primitive polynomial 0x11D (the x^8 term falls off).
  localparam logic [7:0] POLY_LOW = 8'h1D;

  state_e     state_q;
  logic [7:0] idx_q;
  logic [7:0] gen_q;
  logic [7:0] gen_d;

  logic       pend_valid_q;
  logic [7:0] pend_addr_q;
  req_kind_e  pend_kind_q;

  logic [7:0] alpha_q;
  logic       ready_q;
  logic       done_q;

  logic       live_valid;
  req_kind_e  live_kind;
  logic       srv_valid;
  logic [7:0] srv_addr;
  req_kind_e  srv_kind;
  logic [7:0] exp_idx;
  logic [7:0] srv_word;

  logic [7:0] exp_mem [0:254];
`ifdef GF_LOG_LOOKUP_EN
  logic [7:0] log_mem [0:255];
`endif

  // Multiply the generator by alpha: shift left, reduce by the polynomial.
  assign gen_d = {gen_q[6:0], 1'b0} ^ (gen_q[7] ? POLY_LOW : 8'h00);

  // Live request decode with fixed priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    live_valid = 1'b0;
    live_kind  = REQ_ALPHA;
    if (tbl.read_alpha) begin
      live_valid = 1'b1;
      live_kind  = REQ_ALPHA;
    end else if (tbl.read_alpha_inverse) begin
      live_valid = 1'b1;
      live_kind  = REQ_INV;
`ifdef GF_LOG_LOOKUP_EN
    end else if (tbl.read_log) begin
      live_valid = 1'b1;
      live_kind  = REQ_LOG;
`endif
    end
  end

  // A pending request always beats a live one on the same edge.
  always_comb begin
    srv_valid = pend_valid_q | live_valid;
    srv_addr  = pend_valid_q ? pend_addr_q : tbl.address;
    srv_kind  = pend_valid_q ? pend_kind_q : live_kind;
  end

  // Exponent reduction: 255 aliases 0, and alpha^-a = alpha^(255-a).
  always_comb begin
    exp_idx = 8'h00;
    if (srv_kind == REQ_INV) begin
      if (srv_addr != 8'h00 && srv_addr != 8'hFF) exp_idx = 8'hFF - srv_addr;
    end else if (srv_addr != 8'hFF) begin
      exp_idx = srv_addr;
    end
    srv_word = exp_mem[exp_idx];
`ifdef GF_LOG_LOOKUP_EN
    // log(0) is undefined in the field; 8'hFF is the agreed marker.
    if (srv_kind == REQ_LOG) srv_word = (srv_addr == 8'h00) ? 8'hFF : log_mem[srv_addr];
`endif
  end

  // Table storage: written only while building.
  // NOTE: memories carry no reset; the build pass after every reset rewrites them.
  always_ff @(posedge clock) begin
    if (!reset && state_q == ST_INIT) begin
      exp_mem[idx_q] <= gen_q;
`ifdef GF_LOG_LOOKUP_EN
      log_mem[gen_q] <= idx_q;
`endif
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_INIT;
      idx_q        <= 8'h00;
      gen_q        <= 8'h01;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 8'h00;
      pend_kind_q  <= REQ_ALPHA;
      alpha_q      <= 8'h00;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          gen_q <= gen_d;
          idx_q <= idx_q + 8'd1;
          if (idx_q == 8'd254) begin
            state_q <= ST_SERVE;
            done_q  <= 1'b1;
          end
          // Only the most recent request made during the build is kept.
          if (live_valid) begin
            pend_valid_q <= 1'b1;
            pend_addr_q  <= tbl.address;
            pend_kind_q  <= live_kind;
          end
        end
        ST_SERVE: begin
          ready_q      <= srv_valid;
          pend_valid_q <= 1'b0;
          if (srv_valid) alpha_q <= srv_word;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign tbl.alpha           = alpha_q;
  assign tbl.gf_table_ready  = ready_q;
  assign tbl.table_init_done = done_q;

endmodule

// File: tb/tb_gf_alpha_table.sv
// -----------------------------------------------------------------------------
// tb_gf_alpha_table
// Directed bench for gf_alpha_table. Expected words are hand-computed powers of
// alpha in GF(2^8)/0x11D, pushed to a queue when a request is driven; a monitor
// on the falling edge pops one entry per gf_table_ready pulse and also checks
// that alpha holds its last value between responses.
// -----------------------------------------------------------------------------
module tb_gf_alpha_table;

  typedef struct {
    string      name;
    logic [7:0] value;
  } exp_t;

  logic clock;
  logic reset;

  gf_alpha_table_if dut_if ();

  gf_alpha_table dut (
    .clock (clock),
    .reset (reset),
    .tbl   (dut_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic [7:0] last_exp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      last_exp = 8'h00;
    end else if (dut_if.gf_table_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready_pulse", {31'd0, dut_if.gf_table_ready}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {24'd0, dut_if.alpha}, {24'd0, e.value});
        last_exp = e.value;
      end
    end else begin
      check("alpha_hold", {24'd0, dut_if.alpha}, {24'd0, last_exp});
    end
  end

  task automatic clear_strobes();
    dut_if.read_alpha         = 1'b0;
    dut_if.read_alpha_inverse = 1'b0;
`ifdef GF_LOG_LOOKUP_EN
    dut_if.read_log           = 1'b0;
`endif
  endtask

  // Drive one request for a single edge and record its expected response.
  task automatic req(input bit ra, input bit ri, input logic [7:0] a,
                     input logic [7:0] e, input string name);
    exp_t item;
    clear_strobes();
    dut_if.read_alpha         = ra;
    dut_if.read_alpha_inverse = ri;
    dut_if.address            = a;
    item.name  = name;
    item.value = e;
    exp_q.push_back(item);
    @(posedge clock);
    #1;
  endtask

`ifdef GF_LOG_LOOKUP_EN
  task automatic req_log(input logic [7:0] a, input logic [7:0] e, input string name);
    exp_t item;
    clear_strobes();
    dut_if.read_log = 1'b1;
    dut_if.address  = a;
    item.name  = name;
    item.value = e;
    exp_q.push_back(item);
    @(posedge clock);
    #1;
  endtask
`endif

  task automatic idle(input int n);
    clear_strobes();
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Counts edges after reset release until table_init_done (bounded).
  task automatic wait_done(output int edges, output bit saw_ready);
    edges     = 0;
    saw_ready = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (dut_if.gf_table_ready) saw_ready = 1'b1;
      if (dut_if.table_init_done) break;
    end
  endtask

  initial begin
    int  edges;
    bit  saw_ready;
    exp_t item;

    reset          = 1'b1;
    dut_if.address = 8'h00;
    clear_strobes();
    repeat (3) @(posedge clock);
    #1;
    check("reset_alpha", {24'd0, dut_if.alpha}, 32'h00);
    check("reset_ready", {31'd0, dut_if.gf_table_ready}, 32'd0);
    check("reset_done",  {31'd0, dut_if.table_init_done}, 32'd0);

    // Build time.
    reset = 1'b0;
    wait_done(edges, saw_ready);
    check("init_edges", edges, 32'd255);
    check("ready_during_init", {31'd0, saw_ready}, 32'd0);
    idle(2);

    // Back-to-back alpha^a reads.
    req(1'b1, 1'b0, 8'd1,   8'h02, "alpha_a1");
    req(1'b1, 1'b0, 8'd8,   8'h1D, "alpha_a8");
    req(1'b1, 1'b0, 8'd12,  8'hCD, "alpha_a12");
    req(1'b1, 1'b0, 8'd255, 8'h01, "alpha_a255");
    idle(2);

    // Inverse reads and strobe priority.
    req(1'b0, 1'b1, 8'd1, 8'h8E, "inv_a1");
    req(1'b0, 1'b1, 8'd0, 8'h01, "inv_a0");
    idle(1);
    req(1'b1, 1'b1, 8'd1, 8'h02, "both_a1");
    idle(3);

`ifdef GF_LOG_LOOKUP_EN
    req_log(8'h1D, 8'h08, "log_1d");
    req_log(8'h00, 8'hFF, "log_00");
    req_log(8'h8E, 8'hFE, "log_8e");
    idle(3);
`endif

    // Requests during the build: only the last one is served, after edge 256.
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset                     = 1'b0;
    dut_if.read_alpha         = 1'b1;
    dut_if.address            = 8'd1;
    @(posedge clock);
    #1;
    dut_if.address = 8'd2;
    @(posedge clock);
    #1;
    dut_if.address = 8'd3;
    item.name  = "pending_a3";
    item.value = 8'h08;
    exp_q.push_back(item);
    @(posedge clock);
    #1;
    clear_strobes();
    edges = 3;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (dut_if.gf_table_ready) break;
    end
    check("pending_latency", edges, 32'd256);
    idle(2);

    // Reset with a response in flight: it is discarded, outputs clear.
    dut_if.read_alpha = 1'b1;
    dut_if.address    = 8'd8;
    @(posedge clock);
    #1;
    clear_strobes();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("inflight_reset_alpha", {24'd0, dut_if.alpha}, 32'h00);
    check("inflight_reset_ready", {31'd0, dut_if.gf_table_ready}, 32'd0);
    check("inflight_reset_done",  {31'd0, dut_if.table_init_done}, 32'd0);

    // Reset at edge 100 of the build, then a full rebuild.
    reset = 1'b0;
    repeat (99) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_done(edges, saw_ready);
    check("rebuild_edges", edges, 32'd255);
    check("ready_during_rebuild", {31'd0, saw_ready}, 32'd0);
    req(1'b1, 1'b0, 8'd254, 8'h8E, "alpha_a254");
    idle(4);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
